// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RISC-V pipeline.
// Contains the operand forwarding muxes, the ALU, the branch comparator and the
// EX/MEM pipeline register. ex_mem_alu_result is looped back into the
// forwarding muxes, so back-to-back dependent ALU operations need no stall.
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] id_ex_pc,
    input  logic [XLEN-1:0] id_ex_rs1_data,
    input  logic [XLEN-1:0] id_ex_rs2_data,
    input  logic [XLEN-1:0] id_ex_imm,
    input  logic [4:0]      id_ex_rd,
    input  logic [3:0]      id_ex_alu_op,
    input  logic            id_ex_alusrc,
    input  logic            id_ex_regwrite,
    input  logic            id_ex_memread,
    input  logic            id_ex_memwrite,
    input  logic            id_ex_memtoreg,
    input  logic            id_ex_branch,
    input  logic [2:0]      id_ex_funct3,
    input  logic [1:0]      forwardA,
    input  logic [1:0]      forwardB,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] ex_mem_alu_result,
    output logic [XLEN-1:0] ex_mem_store_data,
    output logic [XLEN-1:0] ex_mem_branch_target,
    output logic [4:0]      ex_mem_rd,
    output logic            ex_mem_regwrite,
    output logic            ex_mem_memread,
    output logic            ex_mem_memwrite,
    output logic            ex_mem_memtoreg,
    output logic            ex_mem_branch_taken
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRL  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;

    // Forwarding source select; the unused code 11 falls back to the register file.
    function automatic logic [XLEN-1:0] fwd_sel(input logic [1:0]      sel,
                                                input logic [XLEN-1:0] rf_val,
                                                input logic [XLEN-1:0] exm_val,
                                                input logic [XLEN-1:0] wb_val);
        logic [XLEN-1:0] res;
        case (sel)
            2'b10:   res = exm_val;
            2'b01:   res = wb_val;
            default: res = rf_val;
        endcase
        return res;
    endfunction

    logic [XLEN-1:0] alu_q, store_q, target_q;
    logic [XLEN-1:0] alu_d, store_d, target_d;
    logic [4:0]      rd_q, rd_d;
    logic            regwrite_q, memread_q, memwrite_q, memtoreg_q, taken_q;
    logic            regwrite_d, memread_d, memwrite_d, memtoreg_d, taken_d;

    logic [XLEN-1:0] rs1_fwd, rs2_fwd, op_a, op_b, alu_res;
    logic [4:0]      shamt;
    logic            br_cond;

    assign rs1_fwd = fwd_sel(forwardA, id_ex_rs1_data, alu_q, wb_data);
    assign rs2_fwd = fwd_sel(forwardB, id_ex_rs2_data, alu_q, wb_data);
    assign op_a    = rs1_fwd;
    assign op_b    = id_ex_alusrc ? id_ex_imm : rs2_fwd;
    assign shamt   = op_b[4:0];

    // ALU: result of the selected operation on the forwarded operands.
    always_comb begin
        alu_res = {XLEN{1'b0}};
        case (id_ex_alu_op)
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            default:  alu_res = {XLEN{1'b0}};
        endcase
    end

    // Branch comparator on forwarded rs1/rs2, independent of the immediate select.
    always_comb begin
        br_cond = 1'b0;
        case (id_ex_funct3)
            3'b000:  br_cond = (rs1_fwd == rs2_fwd);
            3'b001:  br_cond = (rs1_fwd != rs2_fwd);
            3'b100:  br_cond = ($signed(rs1_fwd) < $signed(rs2_fwd));
            3'b101:  br_cond = !($signed(rs1_fwd) < $signed(rs2_fwd));
            3'b110:  br_cond = (rs1_fwd < rs2_fwd);
            3'b111:  br_cond = !(rs1_fwd < rs2_fwd);
            default: br_cond = 1'b0;
        endcase
    end

    // EX/MEM next state: flush bubbles the control bits, stall holds everything.
    always_comb begin
        alu_d      = alu_q;
        store_d    = store_q;
        target_d   = target_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        taken_d    = taken_q;
        if (flush) begin
            alu_d      = alu_res;
            store_d    = rs2_fwd;
            target_d   = id_ex_pc + id_ex_imm;
            rd_d       = 5'd0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            memtoreg_d = 1'b0;
            taken_d    = 1'b0;
        end else if (stall) begin
            alu_d      = alu_q;
            store_d    = store_q;
            target_d   = target_q;
            rd_d       = rd_q;
            regwrite_d = regwrite_q;
            memread_d  = memread_q;
            memwrite_d = memwrite_q;
            memtoreg_d = memtoreg_q;
            taken_d    = taken_q;
        end else begin
            alu_d      = alu_res;
            store_d    = rs2_fwd;
            target_d   = id_ex_pc + id_ex_imm;
            rd_d       = id_ex_rd;
            regwrite_d = id_ex_regwrite;
            memread_d  = id_ex_memread;
            memwrite_d = id_ex_memwrite;
            memtoreg_d = id_ex_memtoreg;
            taken_d    = id_ex_branch & br_cond;
        end
    end

    // EX/MEM pipeline register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_q      <= {XLEN{1'b0}};
            store_q    <= {XLEN{1'b0}};
            target_q   <= {XLEN{1'b0}};
            rd_q       <= 5'd0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            taken_q    <= 1'b0;
        end else begin
            alu_q      <= alu_d;
            store_q    <= store_d;
            target_q   <= target_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            taken_q    <= taken_d;
        end
    end

    assign ex_mem_alu_result    = alu_q;
    assign ex_mem_store_data    = store_q;
    assign ex_mem_branch_target = target_q;
    assign ex_mem_rd            = rd_q;
    assign ex_mem_regwrite      = regwrite_q;
    assign ex_mem_memread       = memread_q;
    assign ex_mem_memwrite      = memwrite_q;
    assign ex_mem_memtoreg      = memtoreg_q;
    assign ex_mem_branch_taken  = taken_q;

endmodule
